// File: rtl/pc_sequencer_if.sv
// Fetch and execute handshake bundle between pc_sequencer and its neighbours.
// master = sequencer side; slave = instruction memory / execute datapath side.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ex_start;
    logic        ex_done;
    logic        br_taken;
    logic [15:0] br_off;
    logic        jmp;
    logic [25:0] jmp_idx;
    logic        jr;
    logic [31:0] jr_addr;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output ir,
        output ex_start,
        input  ex_done,
        input  br_taken,
        input  br_off,
        input  jmp,
        input  jmp_idx,
        input  jr,
        input  jr_addr
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  ir,
        input  ex_start,
        output ex_done,
        output br_taken,
        output br_off,
        output jmp,
        output jmp_idx,
        output jr,
        output jr_addr
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle fetch/redirect controller owning the CPU program counter.
// Optional exception path (EXC_VECTOR_EN): exc_req/epc ports, misaligned jr traps.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
`ifdef EXC_VECTOR_EN
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
`endif
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    pc_sequencer_if.master   bus,
`ifdef EXC_VECTOR_EN
    input  logic             exc_req,
    output logic [31:0]      epc,
`endif
    output logic [31:0]      pc,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        EXEC_START = 2'd1,
        EXEC_WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic        fetch_fire;
    logic        retire_fire;
    logic        exc_take;
    logic [31:0] pc4;
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;
    logic [31:0] jr_tgt;
    logic [31:0] next_pc;
    logic [31:0] ir_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    // Strobes are gated by rst so nothing leaks out while reset is held.
    always_comb begin
        state_n      = state;
        bus.imem_req = 1'b0;
        bus.ex_start = 1'b0;
        fetch_fire   = 1'b0;
        retire_fire  = 1'b0;
        unique case (state)
            FETCH: begin
                bus.imem_req = !stall && !rst;
                if (bus.imem_ack && !stall) begin
                    fetch_fire = 1'b1;
                    state_n    = EXEC_START;
                end
            end
            EXEC_START: begin
                bus.ex_start = !stall && !rst;
                if (!stall) begin
                    state_n = EXEC_WAIT;
                end
            end
            EXEC_WAIT: begin
                if (bus.ex_done && !stall) begin
                    retire_fire = 1'b1;
                    state_n     = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    assign pc4     = pc + 32'd4;
    assign br_tgt  = pc4 + {{14{bus.br_off[15]}}, bus.br_off, 2'b00};
    assign jmp_tgt = {pc4[31:28], bus.jmp_idx, 2'b00};
    assign jr_tgt  = {bus.jr_addr[31:2], 2'b00};

    always_comb begin
        next_pc = pc4;
        if (bus.jr) begin
            next_pc = jr_tgt;
        end else if (bus.jmp) begin
            next_pc = jmp_tgt;
        end else if (bus.br_taken) begin
            next_pc = br_tgt;
        end
    end

`ifdef EXC_VECTOR_EN
    assign exc_take = exc_req || (bus.jr && (bus.jr_addr[1:0] != 2'b00));
`else
    logic unused_jr_low;
    assign unused_jr_low = ^bus.jr_addr[1:0];
    assign exc_take      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q <= 32'd0;
        end else if (fetch_fire) begin
            ir_q <= bus.imem_rdata;
        end
    end

    // Trapped instructions redirect but do not count as retired.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= {RESET_PC[31:2], 2'b00};
            retired <= '0;
        end else if (retire_fire) begin
            if (exc_take) begin
`ifdef EXC_VECTOR_EN
                pc <= {EXC_VECTOR[31:2], 2'b00};
`else
                pc <= next_pc;
`endif
            end else begin
                pc      <= next_pc;
                retired <= retired + 1'b1;
            end
        end
    end

`ifdef EXC_VECTOR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            epc <= 32'd0;
        end else if (retire_fire && exc_take) begin
            epc <= pc;
        end
    end
`endif

    assign bus.imem_addr = pc;
    assign bus.ir        = ir_q;

endmodule
